// File: rtl/tpu_loader.sv
// tpu_loader: streams matrix A rows into memA, buffers B rows, replays B reversed
// Ports: clk/rst, start, in_valid/in_ready/in_data, WrEn/Arow/Ain, en/Bin, busy, done
// Option: define LOADER_DRAIN_EN to add a zero-row DRAIN phase after FEED_B
module tpu_loader #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic signed [DIM-1:0][BITS_AB-1:0] in_data,
  output logic                              WrEn,
  output logic [((DIM>1)?$clog2(DIM):1)-1:0] Arow,
  output logic signed [DIM-1:0][BITS_AB-1:0] Ain,
  output logic                              en,
  output logic signed [DIM-1:0][BITS_AB-1:0] Bin,
  output logic                              busy,
  output logic                              done
);

  localparam int AW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [AW-1:0] LAST = AW'(DIM - 1);

`ifdef LOADER_DRAIN_EN
  localparam int DW = $clog2(2 * DIM);
  localparam logic [DW-1:0] DLAST = DW'(2 * DIM - 2);
`endif

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    CAP_B,
`ifdef LOADER_DRAIN_EN
    FEED_B,
    DRAIN
`else
    FEED_B
`endif
  } state_t;

  state_t state, state_n;
  logic [AW-1:0] cnt, cnt_n;
`ifdef LOADER_DRAIN_EN
  logic [DW-1:0] dcnt, dcnt_n;
`endif

  logic signed [DIM-1:0][BITS_AB-1:0] buffer [DIM];

  logic                              xfer;
  logic                              wren_n;
  logic [AW-1:0]                     arow_n;
  logic signed [DIM-1:0][BITS_AB-1:0] ain_n;
  logic                              en_n;
  logic signed [DIM-1:0][BITS_AB-1:0] bin_n;
  logic                              fin, fin_n;

  assign in_ready = (state == LOAD_A) || (state == CAP_B);
  assign busy     = (state != IDLE);
  assign xfer     = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
`ifdef LOADER_DRAIN_EN
      dcnt  <= '0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
`ifdef LOADER_DRAIN_EN
      dcnt  <= dcnt_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
`ifdef LOADER_DRAIN_EN
    dcnt_n  = dcnt;
`endif
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = LOAD_A;
          cnt_n   = '0;
        end
      end
      LOAD_A: begin
        if (xfer) begin
          if (cnt == LAST) begin
            state_n = CAP_B;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      CAP_B: begin
        if (xfer) begin
          if (cnt == LAST) begin
            state_n = FEED_B;
            cnt_n   = LAST;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      FEED_B: begin
        if (cnt == '0) begin
`ifdef LOADER_DRAIN_EN
          state_n = DRAIN;
          dcnt_n  = '0;
`else
          state_n = IDLE;
`endif
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
`ifdef LOADER_DRAIN_EN
      DRAIN: begin
        if (dcnt == DLAST) begin
          state_n = IDLE;
        end else begin
          dcnt_n = dcnt + 1'b1;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  // fin marks the cycle whose registered output is the last en beat;
  // done follows it by one cycle.
  always_comb begin
    wren_n = 1'b0;
    arow_n = Arow;
    ain_n  = Ain;
    en_n   = 1'b0;
    bin_n  = Bin;
    fin_n  = 1'b0;
    unique case (state)
      LOAD_A: begin
        if (xfer) begin
          wren_n = 1'b1;
          arow_n = cnt;
          ain_n  = in_data;
        end
      end
      FEED_B: begin
        en_n  = 1'b1;
        bin_n = buffer[cnt];
`ifndef LOADER_DRAIN_EN
        fin_n = (cnt == '0);
`endif
      end
`ifdef LOADER_DRAIN_EN
      DRAIN: begin
        en_n  = 1'b1;
        bin_n = '0;
        fin_n = (dcnt == DLAST);
      end
`endif
      default: begin
        wren_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      WrEn <= 1'b0;
      Arow <= '0;
      Ain  <= '0;
      en   <= 1'b0;
      Bin  <= '0;
      fin  <= 1'b0;
      done <= 1'b0;
    end else begin
      WrEn <= wren_n;
      Arow <= arow_n;
      Ain  <= ain_n;
      en   <= en_n;
      Bin  <= bin_n;
      fin  <= fin_n;
      done <= fin;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state == CAP_B && xfer) begin
      buffer[cnt] <= in_data;
    end
  end

endmodule

// File: doc/tpu_loader.md
TPU_LOADER -- requirements
Module: tpu_loader

Interface
REQ-001 SHALL have parameter BITS_AB, default 8, meaning element width of A and B matrices.
REQ-002 SHALL have parameter DIM, default 8, meaning matrix dimension (rows, columns, buffer depth).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a load; sampled only in IDLE.
REQ-006 SHALL have port in_valid  input  1  upstream row beat valid.
REQ-007 SHALL have port in_ready  output  1  loader accepts beat; transfer = in_valid & in_ready at clk edge.
REQ-008 SHALL have port in_data  input  DIM x BITS_AB signed  one matrix row; element j at index j.
REQ-009 SHALL have port WrEn  output  1  memA row write enable.
REQ-010 SHALL have port Arow  output  $clog2(DIM)  memA row address.
REQ-011 SHALL have port Ain  output  DIM x BITS_AB signed  memA row data.
REQ-012 SHALL have port en  output  1  shift enable shared by memA and memB.
REQ-013 SHALL have port Bin  output  DIM x BITS_AB signed  memB row data.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse on load completion.

Function
REQ-016 SHALL implement states IDLE, LOAD_A, CAP_B, FEED_B, DRAIN; a row counter of $clog2(DIM) bits wraps DIM-1 -> 0.
REQ-017 IDLE: in_ready=0; start=1 -> LOAD_A with counter=0; start in any other state ignored.
REQ-018 LOAD_A: in_ready=1; each transfer registers WrEn=1, Arow=counter, Ain=in_data for exactly the following cycle, then increments counter; cycles without transfer register WrEn=0.
REQ-019 LOAD_A transfer with counter=DIM-1 -> CAP_B, counter=0.
REQ-020 CAP_B: in_ready=1; each transfer writes in_data into internal buffer entry counter (B row 0 first); WrEn=0, en=0 throughout.
REQ-021 CAP_B transfer with counter=DIM-1 -> FEED_B, counter=DIM-1; beat DIM-1 is buffered before use, so FEED_B never reads an unwritten entry.
REQ-022 FEED_B: in_ready=0; each cycle registers en=1, Bin=buffer[counter], decrements counter; rows issued in order DIM-1 down to 0, one per cycle, no gaps.
REQ-023 FEED_B after issuing row 0 -> DRAIN (LOADER_DRAIN_EN defined) or IDLE with done pulse (undefined).
REQ-024 DRAIN: in_ready=0; registers en=1, Bin=0 for exactly 2*DIM-1 cycles, then -> IDLE with done=1 for one cycle.
REQ-025 en SHALL be high only in FEED_B/DRAIN outputs; WrEn only after LOAD_A transfers; en and WrEn never high in the same cycle.
REQ-026 Ain, Arow, Bin SHALL hold their last value when their enable is low (not required to zero), except as REQ-027/024 state.
REQ-027 Data passed through unmodified; no arithmetic, sign extension or truncation.

Reset
REQ-028 rst=1 at a clk edge SHALL force IDLE, counter=0, and in the next cycle in_ready=0, WrEn=0, Arow=0, Ain=0, en=0, Bin=0, busy=0, done=0.
REQ-029 Reset mid-operation (any state) SHALL abandon the load with no further WrEn/en pulses; buffer contents need not be cleared.
REQ-030 start asserted in the same cycle as rst SHALL be ignored.

Configuration
REQ-031 Macro LOADER_DRAIN_EN defined: DRAIN state compiled in per REQ-024; total en-high cycles per load = 3*DIM-1.
REQ-032 LOADER_DRAIN_EN undefined: DRAIN state absent; done pulses the cycle after the last FEED_B cycle; en-high cycles per load = DIM.

Verification
REQ-033 DIM=8, drain on, in_valid held high, A row i = {i*8+j}, B row i = {-(i*8+j)}: WrEn high 8 cycles with Arow 0..7 in order; en high 23 consecutive cycles; Bin rows 7,6,..,0 then 15 zero rows; done once; in_ready low after 16 transfers.
REQ-034 Backpressure: in_valid toggles 1,0,1,0 in LOAD_A and CAP_B -> still exactly 8 WrEn pulses and 8 buffered rows; FEED_B output identical to REQ-033.
REQ-035 rst=1 in FEED_B after 3 rows issued -> next cycle en=0, busy=0, Bin=0; a new start reloads correctly, matching REQ-033.
REQ-036 start pulsed during LOAD_A and FEED_B -> no effect; start while rst=1 -> stays IDLE.
REQ-037 LOADER_DRAIN_EN undefined, same stimulus as REQ-033 -> en high 8 cycles, done the cycle after Bin row 0.
REQ-038 Boundary values: in_data elements -128 and 127 pass to Ain/Bin bit-exact; counter wrap after row 7 observed as Arow=0 on next load.
